// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control unit: walks the shared datapath through fetch/decode/execute/
// memory/writeback, handshakes with memory via mem_ready and traps on bad opcodes or bus timeouts.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  FETCH    | read instruction at PC, PC += 4 on mem_ready
//  DECODE   | branch target -> ALUOut, dispatch on opcode
//  MEM_ADDR | effective address rs + imm
//  MEM_RD   | load access, wait for mem_ready
//  MEM_WB   | MDR -> rt
//  MEM_WR   | store access, wait for mem_ready
//  R_EX     | rs op rt (funct-decoded)
//  R_WB     | ALUOut -> rd
//  BRANCH   | compare rs/rt, conditional PC <- ALUOut
//  JUMP     | PC <- jump target
//  I_EX     | rs op imm (opcode-decoded)
//  I_WB     | ALUOut -> rt
//  TRAP     | halted until reset
module multicycle_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic [3:0]  state,
   output logic        halted,
   output logic [1:0]  trap_cause,
   output logic [31:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEM_ADDR = 4'd2,
      S_MEM_RD   = 4'd3,
      S_MEM_WB   = 4'd4,
      S_MEM_WR   = 4'd5,
      S_R_EX     = 4'd6,
      S_R_WB     = 4'd7,
      S_BRANCH   = 4'd8,
      S_JUMP     = 4'd9,
      S_I_EX     = 4'd10,
      S_I_WB     = 4'd11,
      S_TRAP     = 4'd12
   } state_t;

   localparam bit         TIMEOUT_EN = (MEM_TIMEOUT != 0);
   localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  wait_q, wait_d;
   logic [1:0]  cause_q, cause_d;
   logic [31:0] retired_q, retired_d;
   logic        retire;
   logic        timeout;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         wait_q    <= 8'd0;
         cause_q   <= 2'b00;
         retired_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         cause_q   <= cause_d;
         retired_q <= retired_d;
      end
   end

   assign timeout = TIMEOUT_EN && !mem_ready && (wait_q == WAIT_LAST);

   always_comb begin
      state_d    = state_q;
      wait_d     = 8'd0;
      cause_d    = cause_q;
      retire     = 1'b0;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_source  = 2'b00;
      halted     = 1'b0;

      unique case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            pc_write  = mem_ready;
            ir_write  = mem_ready;
            if (mem_ready) begin
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               6'h00:                      state_d = S_R_EX;
               6'h23, 6'h2B:               state_d = S_MEM_ADDR;
               6'h04, 6'h05:               state_d = S_BRANCH;
               6'h02:                      state_d = S_JUMP;
               6'h08, 6'h0A, 6'h0C, 6'h0D: state_d = S_I_EX;
               default: begin
                  state_d = S_TRAP;
                  cause_d = 2'b01;
               end
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = (opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD, S_MEM_WR: begin
            iord      = 1'b1;
            mem_read  = (state_q == S_MEM_RD);
            mem_write = (state_q == S_MEM_WR);
            if (mem_ready) begin
               state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
               retire  = (state_q == S_MEM_WR);
            end else if (timeout) begin
               state_d = S_TRAP;
               cause_d = 2'b10;
            end else begin
               wait_d = wait_q + 8'd1;
            end
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            state_d    = S_FETCH;
            retire     = 1'b1;
         end
         S_R_EX: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_R_WB;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            state_d   = S_FETCH;
            retire    = 1'b1;
         end
         S_I_EX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b11;
            state_d   = S_I_WB;
         end
         S_I_WB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
            retire    = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_source = 2'b01;
            pc_write  = ((opcode == 6'h04) && zero) || ((opcode == 6'h05) && !zero);
            state_d   = S_FETCH;
            retire    = 1'b1;
         end
         S_JUMP: begin
            pc_source = 2'b10;
            pc_write  = 1'b1;
            state_d   = S_FETCH;
            retire    = 1'b1;
         end
         default: begin
            halted  = 1'b1;
            state_d = S_TRAP;
         end
      endcase

      retired_d = retire ? retired_q + 32'd1 : retired_q;

      // Reset takes effect at the edge, but requests must drop as soon as rst_n falls.
      if (!rst_n) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         mem_read  = 1'b0;
         mem_write = 1'b0;
         reg_write = 1'b0;
      end
   end

   assign state      = state_q;
   assign trap_cause = cause_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction state sequences with random memory waits,
// random zero flag, traps and resets, checked cycle by cycle against the documented state table.
module tb_multicycle_ctrl_fsm;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  opcode;
   logic        zero;
   logic        mem_ready;
   logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
   logic        reg_dst, mem_to_reg, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic [3:0]  state;
   logic        halted;
   logic [1:0]  trap_cause;
   logic [31:0] retired;
   logic [14:0] ctrl_vec;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_retired = 0;
   logic [1:0]  exp_cause = 2'b00;

   multicycle_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .opcode     (opcode),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .ir_write   (ir_write),
      .iord       (iord),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_source  (pc_source),
      .state      (state),
      .halted     (halted),
      .trap_cause (trap_cause),
      .retired    (retired)
   );

   assign ctrl_vec = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                      mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};

   initial forever #5 clk = ~clk;

   task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected control word for a state number, taken straight from the output table.
   function automatic logic [14:0] exp_ctrl(int st, bit rdy, bit z, logic [5:0] op);
      bit pcw = 0, irw = 0, io = 0, mr = 0, mw = 0, rw = 0, rd = 0, m2r = 0, sa = 0;
      logic [1:0] sb = 2'b00, ao = 2'b00, ps = 2'b00;
      case (st)
         0:  begin mr = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
         1:  sb = 2'b11;
         2:  begin sa = 1; sb = 2'b10; end
         3:  begin mr = 1; io = 1; end
         4:  begin rw = 1; m2r = 1; end
         5:  begin mw = 1; io = 1; end
         6:  begin sa = 1; ao = 2'b10; end
         7:  begin rw = 1; rd = 1; end
         8:  begin sa = 1; ao = 2'b01; ps = 2'b01; pcw = (op == 6'h04 && z) || (op == 6'h05 && !z); end
         9:  begin ps = 2'b10; pcw = 1; end
         10: begin sa = 1; sb = 2'b10; ao = 2'b11; end
         11: rw = 1;
         default: ;
      endcase
      return {pcw, irw, io, mr, mw, rw, rd, m2r, sa, sb, ao, ps};
   endfunction

   task automatic cyc(int st, bit rdy);
      @(negedge clk);
      mem_ready = rdy;
      zero = 1'($urandom_range(0, 1));
      #1;
      check_val("state", 32'(state), 32'(st));
      check_val("ctrl", 32'(ctrl_vec), 32'(exp_ctrl(st, rdy, zero, opcode)));
      check_val("halted", 32'(halted), 32'(st == 12));
      check_val("trap_cause", 32'(trap_cause), 32'(exp_cause));
      check_val("retired", retired, exp_retired);
      @(posedge clk);
   endtask

   task automatic mem_phase(int st, int wn, output bit tr);
      tr = 0;
      for (int i = 0; i <= wn; i++) begin
         cyc(st, i == wn);
         if (i != wn && i == TO - 1) begin
            tr = 1;
            return;
         end
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      check_val("rst_enables", 32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_retired = 0;
      exp_cause = 2'b00;
   endtask

   task automatic trap_and_reset(logic [1:0] cause);
      exp_cause = cause;
      repeat (3) cyc(12, 1'($urandom_range(0, 1)));
      apply_reset();
   endtask

   task automatic run_instr(logic [5:0] op, int wf, int wm);
      bit tr;
      opcode = op;
      mem_phase(0, wf, tr);
      if (tr) begin
         trap_and_reset(2'b10);
         return;
      end
      cyc(1, 1'($urandom_range(0, 1)));
      case (op)
         6'h00: begin cyc(6, 1); cyc(7, 1); end
         6'h08, 6'h0A, 6'h0C, 6'h0D: begin cyc(10, 1); cyc(11, 1); end
         6'h23: begin
            cyc(2, 1);
            mem_phase(3, wm, tr);
            if (tr) begin
               trap_and_reset(2'b10);
               return;
            end
            cyc(4, 1'($urandom_range(0, 1)));
         end
         6'h2B: begin
            cyc(2, 1'($urandom_range(0, 1)));
            mem_phase(5, wm, tr);
            if (tr) begin
               trap_and_reset(2'b10);
               return;
            end
         end
         6'h04, 6'h05: cyc(8, 1'($urandom_range(0, 1)));
         6'h02: cyc(9, 1'($urandom_range(0, 1)));
         default: begin
            trap_and_reset(2'b01);
            return;
         end
      endcase
      exp_retired = exp_retired + 1;
   endtask

   task automatic sw_reset_midaccess();
      opcode = 6'h2B;
      cyc(0, 1);
      cyc(1, 1);
      cyc(2, 1);
      cyc(5, 0);
      @(negedge clk);
      rst_n = 1'b0;
      mem_ready = 1'b0;
      #1;
      check_val("midwr_mem_write", 32'(mem_write), 32'd0);
      check_val("midwr_state", 32'(state), 32'd5);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_retired = 0;
      exp_cause = 2'b00;
   endtask

   logic [5:0] legal_ops [10] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h0A, 6'h0C, 6'h0D};

   initial begin
      rst_n = 1'b0;
      mem_ready = 1'b1;
      zero = 1'b0;
      opcode = 6'h00;
      @(negedge clk);
      #1;
      check_val("init_rst_enables", 32'({pc_write, ir_write, mem_read, mem_write, reg_write}), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_instr(6'h00, 0, 0);
      run_instr(6'h23, 0, 3);
      for (int k = 0; k < 4; k++) run_instr(6'h04, 0, 0);
      for (int k = 0; k < 4; k++) run_instr(6'h05, 0, 0);
      run_instr(6'h02, 0, 0);
      run_instr(6'h08, 0, 0);
      run_instr(6'h0A, 0, 0);
      run_instr(6'h0C, 0, 0);
      run_instr(6'h0D, 0, 0);
      run_instr(6'h2B, 0, 2);
      run_instr(6'h00, 3, 0);
      sw_reset_midaccess();
      run_instr(6'h00, 0, 0);
      run_instr(6'h3F, 0, 0);
      run_instr(6'h00, 4, 0);
      run_instr(6'h23, 0, 4);
      run_instr(6'h2B, 1, 5);

      for (int n = 0; n < 400; n++) begin
         logic [5:0] op;
         int wf, wm;
         if ($urandom_range(0, 15) == 0) op = 6'($urandom);
         else op = legal_ops[$urandom_range(0, 9)];
         wf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
         wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
         run_instr(op, wf, wm);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
